// File: rtl/dbn_mac16_sigmoid_if.sv
// Beat/result bundle for the 16-lane DBN MAC slice: visible data and weight rows in, accumulators and activations out.
// The master drives beats (bench/controller); the slave is the MAC block.
interface dbn_mac16_sigmoid_if;
  logic          in_valid;
  logic          start;
  logic          in_last;
  logic [255:0]  data_in;
  logic [4095:0] weight_in;
  logic [511:0]  acc_out;
  logic [255:0]  sigmoid_out;
  logic          out_valid;

  modport master (
    output in_valid, start, in_last, data_in, weight_in,
    input  acc_out, sigmoid_out, out_valid
  );

  modport slave (
    input  in_valid, start, in_last, data_in, weight_in,
    output acc_out, sigmoid_out, out_valid
  );
endinterface

// File: rtl/dbn_mac16_sigmoid.sv
// 16-lane x 16-element signed Q8.8 MAC into Q16.16 accumulators with a piecewise-linear sigmoid;
// result 1 clock after the last beat, no backpressure (a beat may arrive every cycle).
module dbn_mac16_sigmoid (
  input  logic                 clk,
  input  logic                 rst_n,
  dbn_mac16_sigmoid_if.slave   bus
);
  localparam int LANES = 16;
  localparam int ELEMS = 16;
  localparam int DW    = 16;
  localparam int ACCW  = 32;

  logic [ACCW-1:0] acc_q [LANES];
  logic [ACCW-1:0] acc_d [LANES];
  logic [ACCW-1:0] dot   [LANES];
  logic            out_valid_q;
  logic            out_valid_d;
  logic [LANES*ACCW-1:0] acc_flat;
  logic [LANES*DW-1:0]   sig_flat;

  function automatic logic [15:0] sigmoid_pwl(input logic [ACCW-1:0] x);
    logic [ACCW-1:0] a;
    logic [15:0]     y;
    // |0x80000000| stays 0x80000000, which lands in the saturated segment and yields 0.
    a = x[ACCW-1] ? (~x + 32'd1) : x;
    if (a < 32'h0001_0000)      y = 16'((a >> 3) + 32'h0000_4000);
    else if (a < 32'h0002_6000) y = 16'((a >> 4) + 32'h0000_5000);
    else if (a < 32'h0005_0000) y = 16'((a >> 6) + 32'h0000_6C00);
    else                        y = 16'h8000;
    return x[ACCW-1] ? (16'h8000 - y) : y;
  endfunction

  // The dot product only ever lands in a 32-bit accumulator, so summing mod 2^32 matches the wide sum truncated.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      logic signed [DW-1:0]   d;
      logic signed [DW-1:0]   w;
      logic signed [ACCW-1:0] prod;
      logic [ACCW-1:0]        sum;
      sum = '0;
      for (int k = 0; k < ELEMS; k++) begin
        d    = $signed(bus.data_in[DW*k +: DW]);
        w    = $signed(bus.weight_in[ELEMS*DW*j + DW*k +: DW]);
        prod = d * w;
        sum  = sum + ACCW'(prod);
      end
      dot[j] = sum;
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      acc_d[j] = acc_q[j];
      if (bus.in_valid) begin
        acc_d[j] = (bus.start ? '0 : acc_q[j]) + dot[j];
      end else if (bus.start) begin
        acc_d[j] = '0;
      end
    end
    out_valid_d = bus.in_valid & bus.in_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LANES; j++) begin
        acc_q[j] <= '0;
      end
      out_valid_q <= 1'b0;
    end else begin
      for (int j = 0; j < LANES; j++) begin
        acc_q[j] <= acc_d[j];
      end
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    acc_flat = '0;
    sig_flat = '0;
    for (int j = 0; j < LANES; j++) begin
      acc_flat[ACCW*j +: ACCW] = acc_q[j];
      sig_flat[DW*j +: DW]     = sigmoid_pwl(acc_q[j]);
    end
  end

  assign bus.acc_out     = acc_flat;
  assign bus.sigmoid_out = sig_flat;
  assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_dbn_mac16_sigmoid.sv
// Directed bench for dbn_mac16_sigmoid: inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dbn_mac16_sigmoid;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  dbn_mac16_sigmoid_if bus ();

  dbn_mac16_sigmoid dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_beat(input logic v, input logic s, input logic l,
                            input logic [255:0] d, input logic [4095:0] w);
    @(negedge clk);
    bus.in_valid  = v;
    bus.start     = s;
    bus.in_last   = l;
    bus.data_in   = d;
    bus.weight_in = w;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.in_last   = 1'b0;
    bus.data_in   = '0;
    bus.weight_in = '0;
  endtask

  // Single beat with data elem0 = 0x0100 and lane0 weight0 = w0, so lane0 acc = w0 << 8.
  task automatic point_beat(input logic s, input logic l, input logic [15:0] w0);
    logic [255:0]  d;
    logic [4095:0] w;
    d = '0;
    w = '0;
    d[15:0] = 16'h0100;
    w[15:0] = w0;
    drive_beat(1'b1, s, l, d, w);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.in_last = 1'b0;
    bus.data_in = '0; bus.weight_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.acc_out !== 512'd0) begin
      errors++; $display("FAIL reset_acc: got %h want 0", bus.acc_out);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ov: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.sigmoid_out !== {16{16'h4000}}) begin
      errors++; $display("FAIL reset_sig: got %h want all 4000", bus.sigmoid_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.acc_out !== 512'd0 || bus.out_valid !== 1'b0 || bus.sigmoid_out !== {16{16'h4000}}) begin
      errors++; $display("FAIL reset_idle: acc %h ov %b sig %h want 0/0/all 4000",
                         bus.acc_out, bus.out_valid, bus.sigmoid_out);
    end
  endtask

  task automatic test_single_beat();
    drive_beat(1'b1, 1'b1, 1'b1, {16{16'h0100}}, {256{16'h0100}});
    go_idle();
    checks++;
    if (bus.acc_out !== {16{32'h0010_0000}}) begin
      errors++; $display("FAIL single_acc: got %h want all 00100000", bus.acc_out);
    end
    checks++;
    if (bus.sigmoid_out !== {16{16'h8000}}) begin
      errors++; $display("FAIL single_sig: got %h want all 8000", bus.sigmoid_out);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_ov_high: got %b want 1", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_ov_pulse: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_49_beats();
    logic [255:0]  d;
    logic [4095:0] w;
    int early;
    d = '0; w = '0;
    d[15:0]    = 16'h0100;
    w[15:0]    = 16'h0010;
    w[271:256] = 16'hFFF0;
    early = 0;
    for (int b = 0; b < 49; b++) begin
      drive_beat(1'b1, b == 0, b == 48, d, w);
      if (b > 0 && bus.out_valid !== 1'b0) early++;
    end
    go_idle();
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL vec49_no_early_ov: got %0d early pulses want 0", early);
    end
    checks++;
    if (bus.acc_out !== {{14{32'h0}}, 32'hFFFC_F000, 32'h0003_1000}) begin
      errors++; $display("FAIL vec49_acc: got %h want lane0 00031000 lane1 FFFCF000", bus.acc_out);
    end
    checks++;
    if (bus.sigmoid_out !== {{14{16'h4000}}, 16'h07C0, 16'h7840}) begin
      errors++; $display("FAIL vec49_sig: got %h want lane0 7840 lane1 07C0 rest 4000", bus.sigmoid_out);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL vec49_ov: got %b want 1", bus.out_valid);
    end
  endtask

  task automatic test_segments();
    logic [15:0] w0s  [5] = '{16'h0100, 16'hFF00, 16'h0500, 16'h0260, 16'h025F};
    logic [31:0] accs [5] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0005_0000, 32'h0002_6000, 32'h0002_5F00};
    logic [15:0] sigs [5] = '{16'h6000, 16'h2000, 16'h8000, 16'h7580, 16'h75F0};
    for (int i = 0; i < 5; i++) begin
      point_beat(1'b1, 1'b1, w0s[i]);
      go_idle();
      checks++;
      if (bus.acc_out[31:0] !== accs[i] || bus.sigmoid_out[15:0] !== sigs[i]) begin
        errors++; $display("FAIL seg_%0d: acc %h sig %h want %h %h",
                           i, bus.acc_out[31:0], bus.sigmoid_out[15:0], accs[i], sigs[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [255:0]  d;
    logic [4095:0] w;
    drive_beat(1'b1, 1'b1, 1'b1, {16{16'h7FFF}}, {256{16'h7FFF}});
    go_idle();
    checks++;
    if (bus.acc_out !== {16{32'hFFF0_0010}} || bus.sigmoid_out !== {16{16'h0000}}) begin
      errors++; $display("FAIL wrap: acc %h sig %h want all FFF00010 / 0000",
                         bus.acc_out[31:0], bus.sigmoid_out[15:0]);
    end
    // Two products of -32768 * -32768 reach exactly 0x80000000.
    d = '0; w = '0;
    d[31:0] = {16'h8000, 16'h8000};
    w[31:0] = {16'h8000, 16'h8000};
    drive_beat(1'b1, 1'b1, 1'b1, d, w);
    go_idle();
    checks++;
    if (bus.acc_out[31:0] !== 32'h8000_0000 || bus.sigmoid_out[15:0] !== 16'h0000) begin
      errors++; $display("FAIL most_negative: acc %h sig %h want 80000000 / 0000",
                         bus.acc_out[31:0], bus.sigmoid_out[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    drive_beat(1'b1, 1'b1, 1'b1, {16{16'h0100}}, {256{16'h0100}});
    point_beat(1'b1, 1'b1, 16'h0100);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.acc_out[31:0] !== 32'h0010_0000) begin
      errors++; $display("FAIL b2b_a: ov %b acc %h want 1 / 00100000", bus.out_valid, bus.acc_out[31:0]);
    end
    go_idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.acc_out !== {{15{32'h0}}, 32'h0001_0000}) begin
      errors++; $display("FAIL b2b_b: ov %b acc %h want 1 / lane0 00010000 only", bus.out_valid, bus.acc_out);
    end

    // Abandoned vector: restart mid-vector, only the new sum completes.
    point_beat(1'b1, 1'b0, 16'h0300);
    point_beat(1'b0, 1'b0, 16'h0300);
    point_beat(1'b1, 1'b0, 16'h0100);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.acc_out[31:0] !== 32'h0006_0000) begin
      errors++; $display("FAIL abandon_mid: ov %b acc %h want 0 / 00060000", bus.out_valid, bus.acc_out[31:0]);
    end
    point_beat(1'b0, 1'b1, 16'h0100);
    go_idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.acc_out[31:0] !== 32'h0002_0000) begin
      errors++; $display("FAIL abandon_new: ov %b acc %h want 1 / 00020000", bus.out_valid, bus.acc_out[31:0]);
    end

    // Start without a beat clears the accumulators.
    point_beat(1'b1, 1'b0, 16'h0200);
    drive_beat(1'b0, 1'b1, 1'b0, '0, '0);
    go_idle();
    checks++;
    if (bus.acc_out !== 512'd0 || bus.out_valid !== 1'b0 || bus.sigmoid_out[15:0] !== 16'h4000) begin
      errors++; $display("FAIL start_clear: acc %h ov %b want 0 / 0", bus.acc_out[31:0], bus.out_valid);
    end

    // Reset mid-vector: the last beat was consumed just before reset, so its pulse must vanish.
    point_beat(1'b1, 1'b0, 16'h0200);
    point_beat(1'b0, 1'b1, 16'h0200);
    go_idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.acc_out !== 512'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: acc %h ov %b want 0 / 0", bus.acc_out[31:0], bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0 || bus.acc_out !== 512'd0) begin
        errors++; $display("FAIL reset_mid_after: pulses %0d acc %h want 0 / 0", pulses, bus.acc_out[31:0]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_beat();
    test_49_beats();
    test_segments();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
